// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus receiver.
//   - HD44780 instruction opcode bits (highest set bit selects the command)
//   - two-line DDRAM address map constants and the address step helper
//   - receiver state enum
package lcd_pkg;

  typedef enum logic [1:0] {INIT8, HI, LO, CLEAR} rx_state_e;

  localparam logic [7:0] OP_DDRAM = 8'h80;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] FUNC_DL  = 8'h10;

  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;
  localparam logic [7:0] CHAR_BLANK = 8'h20;
  localparam logic [4:0] CLR_LAST   = 5'd31;

  // Address counter step on the two-line map: the gaps 0x28..0x3F and
  // 0x68..0x7F are skipped, and the map wraps between the two lines.
  function automatic logic [6:0] addr_step(input logic [6:0] ad, input logic inc);
    logic [6:0] nx;
    if (inc) begin
      if (ad == LINE1_LAST)      nx = LINE2_BASE;
      else if (ad == LINE2_LAST) nx = 7'h00;
      else                       nx = ad + 7'd1;
    end else begin
      if (ad == 7'h00)           nx = LINE2_LAST;
      else if (ad == LINE2_BASE) nx = LINE1_LAST;
      else                       nx = ad - 7'd1;
    end
    return nx;
  endfunction

  // Addresses that do not exist on a two-line panel.
  function automatic logic addr_reserved(input logic [6:0] ad);
    return ((ad > LINE1_LAST) && (ad < LINE2_BASE)) || (ad > LINE2_LAST);
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character buffer: one synchronous write port, one registered read
// port. Read-during-write to the same index returns the old contents.
// rdata resets to a blank; array contents are blanked by the owner's
// clear sequence after reset.
//   clk, rst_n       clock, async active-low reset (read register only)
//   we, waddr, wdata write port
//   raddr, rdata     read port, 1-cycle latency
module lcd_char_ram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= CHAR_BLANK;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Responder for the 4-bit character-LCD write bus. Decodes falling-edge
// strobes into HD44780 instructions/data and mirrors the 2-line display
// into a 32-entry character buffer.
//   bus in:   sf_e, e, rs, rw, d/c/b/a (nibble, d = bit 3)
//   read:     rd_addr -> rd_char (1-cycle latency)
//   stream:   byte_valid pulse, byte_data, byte_rs
//   state:    mode_4bit, ddram_addr, display_on, cursor_on, blink_on,
//             inc_dec, busy (clear in progress), proto_err (sticky)
// Build option: LCD_RX_SYNC_EN adds a 2-flop synchronizer on all bus
// inputs for asynchronous sources (+2 cycles on every strobe latency).
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int LINE_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sf_e,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic       d,
  input  logic       c,
  input  logic       b,
  input  logic       a,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       mode_4bit,
  output logic [6:0] ddram_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_dec,
  output logic       busy,
  output logic       proto_err
);

  localparam logic [6:0] LL = 7'(LINE_LEN);

  logic [7:0] bus_raw, bus;
  assign bus_raw = {sf_e, e, rs, rw, d, c, b, a};

`ifdef LCD_RX_SYNC_EN
  logic [7:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus_raw;
      sync2 <= sync1;
    end
  end
  assign bus = sync2;
`else
  assign bus = bus_raw;
`endif

  logic       bus_sf_e, bus_e, bus_rs, bus_rw;
  logic [3:0] nib;
  assign {bus_sf_e, bus_e, bus_rs, bus_rw, nib} = bus;

  logic       e_q, strobe;
  rx_state_e  state;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic       clr_start;
  logic [4:0] clr_cnt;
  logic [7:0] asm_byte;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;

  assign strobe   = e_q & ~bus_e & bus_sf_e & ~bus_rw;
  assign asm_byte = {hi_nib, nib};

  function automatic logic visible(input logic [6:0] ad);
    return (ad < LL) || ((ad >= LINE2_BASE) && (ad < LINE2_BASE + LL));
  endfunction

  // Clear sequence owns the write port; otherwise a data byte landing on a
  // visible address is written. Line is selected by address bit 6.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (busy) begin
      we    = 1'b1;
      waddr = clr_cnt;
      wdata = CHAR_BLANK;
    end else if (strobe && !clr_start && state == LO && bus_rs && visible(ddram_addr)) begin
      we    = 1'b1;
      waddr = {ddram_addr[6], ddram_addr[3:0]};
      wdata = asm_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= 1'b0;
    else        e_q <= bus_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT8;
      hi_nib     <= '0;
      hi_rs      <= 1'b0;
      clr_start  <= 1'b1;  // blank the buffer once after every reset
      clr_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_rs    <= 1'b0;
      mode_4bit  <= 1'b0;
      ddram_addr <= '0;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      inc_dec    <= 1'b1;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clr_start) begin
        clr_start <= 1'b0;
        busy      <= 1'b1;
        clr_cnt   <= '0;
      end else if (busy) begin
        clr_cnt <= clr_cnt + 5'd1;
        if (clr_cnt == CLR_LAST) begin
          busy <= 1'b0;
          if (state == CLEAR) state <= HI;
        end
      end

      if (strobe) begin
        if (busy || clr_start || state == CLEAR) begin
          proto_err <= 1'b1;  // controller cannot accept writes while clearing
        end else begin
          unique case (state)
            INIT8: begin
              if (nib == 4'h2 && !bus_rs) begin
                state     <= HI;
                mode_4bit <= 1'b1;
              end else if (nib != 4'h3) begin
                proto_err <= 1'b1;
              end
            end
            HI: begin
              hi_nib <= nib;
              hi_rs  <= bus_rs;
              state  <= LO;
            end
            LO: begin
              state      <= HI;
              byte_valid <= 1'b1;
              byte_data  <= asm_byte;
              byte_rs    <= bus_rs;
              if (bus_rs != hi_rs) proto_err <= 1'b1;
              if (bus_rs) begin
                ddram_addr <= addr_step(ddram_addr, inc_dec);
              end else if ((asm_byte & OP_DDRAM) != 0) begin
                ddram_addr <= asm_byte[6:0];
                if (addr_reserved(asm_byte[6:0])) proto_err <= 1'b1;
              end else if ((asm_byte & OP_CGRAM) != 0) begin
                // CGRAM not modelled
              end else if ((asm_byte & OP_FUNC) != 0) begin
                if ((asm_byte & FUNC_DL) != 0) begin
                  state     <= INIT8;
                  mode_4bit <= 1'b0;
                end
              end else if ((asm_byte & OP_SHIFT) != 0) begin
                // shifts do not alter the buffer mirror
              end else if ((asm_byte & OP_DISP) != 0) begin
                {display_on, cursor_on, blink_on} <= asm_byte[2:0];
              end else if ((asm_byte & OP_ENTRY) != 0) begin
                inc_dec <= asm_byte[1];
              end else if ((asm_byte & OP_HOME) != 0) begin
                ddram_addr <= '0;
              end else if ((asm_byte & OP_CLEAR) != 0) begin
                ddram_addr <= '0;
                inc_dec    <= 1'b1;
                state      <= CLEAR;
                busy       <= 1'b1;
                clr_cnt    <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  lcd_char_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: init handshake, instruction and data
// decode, address wrap, ignored strobes, clear timing and error flags.
module tb_lcd_bus_receiver;

  logic       clk = 0, rst_n = 0;
  logic       sf_e = 0, e = 0, rs = 0, rw = 0, d = 0, c = 0, b = 0, a = 0;
  logic [4:0] rd_addr = 0;
  logic [7:0] rd_char, byte_data;
  logic       byte_valid, byte_rs, mode_4bit, display_on, cursor_on, blink_on;
  logic       inc_dec, busy, proto_err;
  logic [6:0] ddram_addr;

  int n_chk = 0, n_err = 0;
  int busy_cnt = 0;
  logic [7:0] bv_q[$];
  logic [7:0] exp_buf[32];
  logic [7:0] rv;

  always #10 clk = ~clk;

  lcd_bus_receiver #(.LINE_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .sf_e(sf_e), .e(e), .rs(rs), .rw(rw),
    .d(d), .c(c), .b(b), .a(a), .rd_addr(rd_addr), .rd_char(rd_char),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs),
    .mode_4bit(mode_4bit), .ddram_addr(ddram_addr), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .inc_dec(inc_dec),
    .busy(busy), .proto_err(proto_err)
  );

  always @(negedge clk) begin
    if (rst_n && byte_valid) bv_q.push_back(byte_data);
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic r, input logic [3:0] nib,
                        input logic rdwr = 1'b0, input logic sel = 1'b1);
    @(posedge clk); #1;
    sf_e = sel; rs = r; rw = rdwr; {d, c, b, a} = nib; e = 1;
    repeat (2) @(posedge clk);
    #1 e = 0;
    repeat (4) @(posedge clk);
    #1 sf_e = 0; rw = 0;
  endtask

  task automatic send_byte(input logic r, input logic [7:0] v);
    strobe(r, v[7:4]);
    strobe(r, v[3:0]);
  endtask

  task automatic wait_idle();
    int  n = 0;
    bit  seen = 0;
    while (n < 200) begin
      @(negedge clk);
      if (busy) seen = 1;
      else if (seen) break;
      n++;
    end
    chk("idle_timeout", n < 200, 1);
  endtask

  task automatic read_char(input logic [4:0] idx, output logic [7:0] v);
    @(posedge clk); #1 rd_addr = idx;
    @(posedge clk); #1 v = rd_char;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_char", rd_char, 8'h20);
    chk("rst_inc_dec", inc_dec, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mode", mode_4bit, 0);
    chk("rst_addr", ddram_addr, 0);
    chk("rst_disp", {display_on, cursor_on, blink_on, byte_valid, proto_err}, 0);

    // post-reset clear
    busy_cnt = 0;
    #3 rst_n = 1;
    wait_idle();
    chk("rst_clear_len", busy_cnt, 32);
    read_char(5'd0, rv);
    chk("rst_blank", rv, 8'h20);

    // 8-bit init then switch to 4-bit
    strobe(0, 4'h3); strobe(0, 4'h3); strobe(0, 4'h3);
    chk("init_still8", mode_4bit, 0);
    strobe(0, 4'h2);
    chk("init_4bit", mode_4bit, 1);
    chk("init_no_bv", bv_q.size(), 0);
    chk("init_err", proto_err, 0);

    // configuration bytes
    send_byte(0, 8'h28);
    send_byte(0, 8'h06);
    send_byte(0, 8'h0C);
    busy_cnt = 0;
    send_byte(0, 8'h01);
    wait_idle();
    chk("clr_len", busy_cnt, 32);
    chk("cfg_bv_n", bv_q.size(), 4);
    if (bv_q.size() == 4) begin
      chk("cfg_bv0", bv_q[0], 8'h28);
      chk("cfg_bv1", bv_q[1], 8'h06);
      chk("cfg_bv2", bv_q[2], 8'h0C);
      chk("cfg_bv3", bv_q[3], 8'h01);
    end
    chk("cfg_dcb", {display_on, cursor_on, blink_on}, 3'b100);
    chk("cfg_addr", ddram_addr, 0);
    chk("cfg_incdec", inc_dec, 1);
    chk("cfg_err", proto_err, 0);

    // data writes on both lines
    send_byte(1, 8'h48); exp_buf[0] = 8'h48;
    send_byte(1, 8'h65); exp_buf[1] = 8'h65;
    send_byte(0, 8'hC0);
    send_byte(1, 8'h57); exp_buf[16] = 8'h57;
    chk("data_rs", byte_rs, 1);
    chk("data_addr", ddram_addr, 7'h41);
    read_char(5'd0, rv);  chk("data_e0", rv, 8'h48);
    read_char(5'd1, rv);  chk("data_e1", rv, 8'h65);
    read_char(5'd16, rv); chk("data_e16", rv, 8'h57);

    // invisible write at end of line 1 region, wrap to line 2
    send_byte(0, 8'hA7);
    chk("wrap_set", ddram_addr, 7'h27);
    send_byte(1, 8'h41);
    chk("wrap_inc", ddram_addr, 7'h40);
    for (int i = 0; i < 32; i++) begin
      read_char(5'(i), rv);
      chk($sformatf("buf_%0d", i), rv, exp_buf[i]);
    end
    send_byte(0, 8'h04);
    chk("entry_dec", inc_dec, 0);
    send_byte(0, 8'h80);
    send_byte(1, 8'h5A); exp_buf[0] = 8'h5A;
    chk("wrap_dec", ddram_addr, 7'h67);
    read_char(5'd0, rv); chk("dec_e0", rv, 8'h5A);
    chk("wrap_err", proto_err, 0);

    // ignored strobes between nibbles
    send_byte(0, 8'h06);
    send_byte(0, 8'h80);
    strobe(1, 4'h4);
    strobe(0, 4'h0, 1'b1, 1'b1);  // busy-flag read
    strobe(0, 4'h0, 1'b0, 1'b0);  // flash owns the bus
    strobe(1, 4'h8);
    chk("ign_bv", bv_q[$], 8'h48);
    chk("ign_addr", ddram_addr, 7'h01);
    read_char(5'd0, rv); chk("ign_e0", rv, 8'h48);
    chk("ign_err", proto_err, 0);

    // strobe during clear is dropped
    send_byte(0, 8'h01);
    chk("clr_busy", busy, 1);
    strobe(1, 4'h7);
    chk("clr_err", proto_err, 1);
    wait_idle();
    send_byte(1, 8'h31);
    read_char(5'd0, rv); chk("clr_phase", rv, 8'h31);
    read_char(5'd16, rv); chk("clr_blank", rv, 8'h20);

    // reset mid-byte
    send_byte(0, 8'h0F);
    strobe(1, 4'h6);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("mrst_mode", mode_4bit, 0);
    chk("mrst_err", proto_err, 0);
    chk("mrst_disp", {display_on, cursor_on, blink_on}, 0);
    chk("mrst_addr", ddram_addr, 0);
    #3 rst_n = 1;
    wait_idle();
    bv_q.delete();
    strobe(0, 4'h3);
    chk("mrst_init8", mode_4bit, 0);
    strobe(0, 4'h2);
    chk("mrst_4bit", mode_4bit, 1);
    chk("mrst_no_bv", bv_q.size(), 0);

    // reserved address flags an error but still loads
    send_byte(0, 8'hA8);
    chk("rsv_addr", ddram_addr, 7'h28);
    chk("rsv_err", proto_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
